// File: rtl/mmio_uart_ctrl.sv
// mmio_uart_ctrl
//   MMIO register window for a small CPU. It bridges a byte-wide UART
//   (TX and RX handshakes) and exposes free-running cycle and
//   retired-instruction counters.
//
// Register map (offset = addr[7:0]; the window is selected by
// addr[31:28] == ADDR_BASE[31:28]):
//   0x00  R  status   {30'b0, rx_full, tx_space}
//   0x04  R  RX data  {24'b0, rx_byte}; the read pops the byte
//   0x08  W  TX data  wdata[7:0]
//   0x10  R  cycle count
//   0x14  R  retired-instruction count
//   0x18  W  counter reset (clears both counters, data ignored)
//
// Parameters:
//   ADDR_BASE   base of the MMIO window (only bits [31:28] are decoded)
//   FIFO_DEPTH  TX FIFO entries, a power of 2 no smaller than 2. It is
//               used only when MMIO_TX_FIFO_EN is defined.
//
// Build option:
//   MMIO_TX_FIFO_EN  defined   : TX bytes pass through a FIFO_DEPTH-entry FIFO.
//                    undefined : TX uses a single holding register, and a
//                                store made while it is full is dropped.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   addr         EX-stage byte address
//   wdata        store data; the TX byte is in [7:0]
//   we, re       store strobe and load strobe
//   inst_retire  one instruction retired this cycle
//   rdata        registered load data (1-cycle latency, 0 when not selected)
//   tx_data, tx_valid, tx_ready   byte stream to the UART
//   rx_data, rx_valid, rx_ready   byte stream from the UART
module mmio_uart_ctrl #(
    parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic        inst_retire,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam logic [7:0] OFF_STATUS = 8'h00;
    localparam logic [7:0] OFF_RXDATA = 8'h04;
    localparam logic [7:0] OFF_TXDATA = 8'h08;
    localparam logic [7:0] OFF_CYCLE  = 8'h10;
    localparam logic [7:0] OFF_INST   = 8'h14;
    localparam logic [7:0] OFF_CNTCLR = 8'h18;

    logic        sel;
    logic [7:0]  off;
    logic        tx_wr;
    logic        rx_pop;
    logic        cnt_clr;
    logic        tx_space;
    logic        rx_full;
    logic [7:0]  rx_byte;
    logic [31:0] cycle_cnt;
    logic [31:0] inst_cnt;

    assign sel     = (addr[31:28] == ADDR_BASE[31:28]);
    assign off     = addr[7:0];
    assign tx_wr   = we && sel && (off == OFF_TXDATA);
    assign rx_pop  = re && sel && (off == OFF_RXDATA) && rx_full;
    assign cnt_clr = we && sel && (off == OFF_CNTCLR);

    assign rx_ready = !rx_full;

    // The load mux samples state before the edge, so a load that coincides
    // with a store or a pop returns the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re && sel) begin
            case (off)
                OFF_STATUS: rdata <= {30'b0, rx_full, tx_space};
                OFF_RXDATA: rdata <= {24'b0, rx_byte};
                OFF_CYCLE:  rdata <= cycle_cnt;
                OFF_INST:   rdata <= inst_cnt;
                default:    rdata <= '0;
            endcase
        end else begin
            rdata <= '0;
        end
    end

    // RX holding register. While it is full, rx_ready is low, so the
    // latch and the pop never happen at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_full <= 1'b0;
            rx_byte <= '0;
        end else if (rx_valid && !rx_full) begin
            rx_full <= 1'b1;
            rx_byte <= rx_data;
        end else if (rx_pop) begin
            rx_full <= 1'b0;
        end
    end

    // The counter reset takes precedence over that cycle's increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (inst_retire) begin
                inst_cnt <= inst_cnt + 32'd1;
            end
        end
    end

`ifdef MMIO_TX_FIFO_EN
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic          fifo_full;
    logic          push;
    logic          pop;

    // Fullness is taken from the registered count. A store that arrives
    // while the FIFO is full is dropped, even if a pop frees a slot at
    // the same edge.
    assign fifo_full = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign push      = tx_wr && !fifo_full;
    assign pop       = tx_valid && tx_ready;
    assign tx_valid  = (fifo_cnt != '0);
    assign tx_data   = fifo_mem[rd_ptr];
    assign tx_space  = !fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= wdata[7:0];
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_cnt <= fifo_cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    logic unused_ok;
    assign unused_ok = ^{wdata[31:8], addr[27:8]};
`else
    assign tx_space = !tx_valid;

    // A store made while a byte is held is dropped, even in the cycle
    // in which that byte is being accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (tx_valid) begin
            if (tx_ready) begin
                tx_valid <= 1'b0;
            end
        end else if (tx_wr) begin
            tx_valid <= 1'b1;
            tx_data  <= wdata[7:0];
        end
    end

    logic [31:0] unused_depth;
    logic        unused_ok;
    assign unused_depth = FIFO_DEPTH;
    assign unused_ok    = ^{wdata[31:8], addr[27:8], unused_depth};
`endif

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
module tb_mmio_uart_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        inst_retire;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int checks;
    int errors;

    mmio_uart_ctrl #(
        .ADDR_BASE (32'h8000_0000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wdata      (wdata),
        .we         (we),
        .re         (re),
        .inst_retire(inst_retire),
        .rdata      (rdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0);
        end
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_tx got=%b/%h exp=0/00", tx_valid, tx_data);
        end
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_rx_ready got=%b exp=1", rx_ready);
        end
        // five idle edges, then the load is sampled on the sixth edge
        repeat (5) tick();
        re   = 1'b1;
        addr = 32'h8000_0010;
        tick();
        checks++;
        if (rdata !== 32'd5) begin
            errors++;
            $display("FAIL reset_cycle_cnt got=%h exp=%h", rdata, 32'd5);
        end
        addr = 32'h8000_0000;
        tick();
        checks++;
        if (rdata !== 32'h1) begin
            errors++;
            $display("FAIL reset_status got=%h exp=%h", rdata, 32'h1);
        end
        re = 1'b0;
    endtask

    task automatic test_decode();
        re   = 1'b1;
        addr = 32'h8000_0008;
        tick();
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL decode_wo_load got=%h exp=0", rdata);
        end
        addr = 32'h8000_000C;
        tick();
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL decode_unmapped got=%h exp=0", rdata);
        end
        addr = 32'h9000_0010;
        tick();
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL decode_outside got=%h exp=0", rdata);
        end
        re   = 1'b0;
        addr = 32'h8000_0010;
        tick();
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL decode_no_re got=%h exp=0", rdata);
        end
        // a store to the read-only status register changes nothing
        we    = 1'b1;
        addr  = 32'h8000_0000;
        wdata = 32'hFFFF_FFFF;
        tick();
        we   = 1'b0;
        re   = 1'b1;
        tick();
        re = 1'b0;
        checks++;
        if (rdata !== 32'h1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL decode_ro_store got=%h/%b exp=00000001/0", rdata, tx_valid);
        end
    endtask

    task automatic test_rx();
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        tick();
        checks++;
        if (rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL rx_ready_full got=%b exp=0", rx_ready);
        end
        // this byte arrives while the register is full and must be ignored
        rx_data = 8'h77;
        tick();
        rx_valid = 1'b0;
        re       = 1'b1;
        addr     = 32'h8000_0000;
        tick();
        checks++;
        if (rdata !== 32'h3) begin
            errors++;
            $display("FAIL rx_status_full got=%h exp=%h", rdata, 32'h3);
        end
        addr = 32'h8000_0004;
        tick();
        checks++;
        if (rdata !== 32'h5A) begin
            errors++;
            $display("FAIL rx_data got=%h exp=%h", rdata, 32'h5A);
        end
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL rx_ready_popped got=%b exp=1", rx_ready);
        end
        addr = 32'h8000_0000;
        tick();
        checks++;
        if (rdata !== 32'h1) begin
            errors++;
            $display("FAIL rx_status_empty got=%h exp=%h", rdata, 32'h1);
        end
        addr = 32'h8000_0004;
        tick();
        checks++;
        if (rdata !== 32'h5A || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL rx_stale got=%h/%b exp=0000005a/1", rdata, rx_ready);
        end
        re = 1'b0;
    endtask

`ifdef MMIO_TX_FIFO_EN
    task automatic test_tx_fifo();
        logic [7:0] exp_b;
        tx_ready = 1'b0;
        we       = 1'b1;
        addr     = 32'h8000_0008;
        for (int i = 0; i < 4; i++) begin
            wdata = 32'h10 + i;
            tick();
        end
        we   = 1'b0;
        re   = 1'b1;
        addr = 32'h8000_0000;
        tick();
        re = 1'b0;
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL fifo_status_full got=%h exp=0", rdata);
        end
        // the FIFO is full, so this push is dropped
        we    = 1'b1;
        addr  = 32'h8000_0008;
        wdata = 32'h14;
        tick();
        we       = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_b = 8'h10 + 8'(i);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b) begin
                errors++;
                $display("FAIL fifo_order[%0d] got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_b);
            end
            tick();
        end
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL fifo_drained got=%b exp=0", tx_valid);
        end
        tx_ready = 1'b0;
    endtask
`else
    task automatic test_tx_holding();
        tx_ready = 1'b0;
        we       = 1'b1;
        addr     = 32'h8000_0008;
        wdata    = 32'h41;
        tick();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
            errors++;
            $display("FAIL tx_first got=%b/%h exp=1/41", tx_valid, tx_data);
        end
        wdata = 32'h42;
        tick();
        we = 1'b0;
        tick();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
            errors++;
            $display("FAIL tx_hold got=%b/%h exp=1/41", tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL tx_accepted got=%b exp=0", tx_valid);
        end
        tick();
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL tx_dropped got=%b exp=0", tx_valid);
        end
        we    = 1'b1;
        wdata = 32'h43;
        tick();
        we = 1'b0;
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h43) begin
            errors++;
            $display("FAIL tx_reload got=%b/%h exp=1/43", tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask
`endif

    task automatic test_counter_wrap();
        re   = 1'b1;
        addr = 32'h8000_0010;
        force dut.cycle_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_cnt;
        tick();
        checks++;
        if (rdata !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL wrap_fe got=%h exp=fffffffe", rdata);
        end
        tick();
        checks++;
        if (rdata !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_ff got=%h exp=ffffffff", rdata);
        end
        tick();
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL wrap_zero got=%h exp=0", rdata);
        end
        re = 1'b0;
    endtask

    task automatic test_counter_clear();
        inst_retire = 1'b1;
        tick();
        re   = 1'b1;
        addr = 32'h8000_0014;
        tick();
        checks++;
        if (rdata !== 32'd1) begin
            errors++;
            $display("FAIL inst_count got=%h exp=1", rdata);
        end
        // third retire cycle also carries the counter reset store
        re   = 1'b0;
        we   = 1'b1;
        addr = 32'h8000_0018;
        wdata = 32'h0;
        tick();
        we          = 1'b0;
        inst_retire = 1'b0;
        re          = 1'b1;
        addr        = 32'h8000_0010;
        tick();
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL clr_cycle got=%h exp=0", rdata);
        end
        addr = 32'h8000_0014;
        tick();
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL clr_inst got=%h exp=0", rdata);
        end
        addr = 32'h8000_0010;
        tick();
        checks++;
        if (rdata !== 32'd2) begin
            errors++;
            $display("FAIL clr_cycle_runs got=%h exp=2", rdata);
        end
        re = 1'b0;
    endtask

    task automatic test_reset_midflight();
        tx_ready = 1'b0;
        we       = 1'b1;
        addr     = 32'h8000_0008;
        wdata    = 32'h99;
        tick();
        we       = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h33;
        tick();
        checks++;
        if (tx_valid !== 1'b1 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_setup got=%b/%b exp=1/0", tx_valid, rx_ready);
        end
        rst  = 1'b1;
        re   = 1'b1;
        addr = 32'h8000_0004;
        tick();
        rst      = 1'b0;
        rx_valid = 1'b0;
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || rx_ready !== 1'b1 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset got=%b/%h/%b/%h exp=0/00/1/00000000", tx_valid, tx_data, rx_ready, rdata);
        end
        addr = 32'h8000_0010;
        tick();
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_cycle got=%h exp=0", rdata);
        end
        addr = 32'h8000_0014;
        tick();
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_inst got=%h exp=0", rdata);
        end
        re = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        addr        = '0;
        wdata       = '0;
        we          = 1'b0;
        re          = 1'b0;
        inst_retire = 1'b0;
        tx_ready    = 1'b0;
        rx_data     = '0;
        rx_valid    = 1'b0;
        #2;
        test_reset();
        test_decode();
        test_rx();
`ifdef MMIO_TX_FIFO_EN
        test_tx_fifo();
`else
        test_tx_holding();
`endif
        test_counter_wrap();
        test_counter_clear();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_uart_ctrl.md
MMIO_UART_CTRL -- requirements
Module: mmio_uart_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_BASE, default 32'h8000_0000, the MMIO window base; the window is selected when addr[31:28]==ADDR_BASE[31:28].
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, the TX FIFO entries (power of 2, used only when MMIO_TX_FIFO_EN is defined).
REQ-003 The block SHALL have these ports:
  clk  in  1  clock
  rst  in  1  reset, synchronous, active-high
  addr  in  32  EX-stage ALU byte address
  wdata  in  32  store data (byte in [7:0])
  we  in  1  store strobe
  re  in  1  load strobe
  inst_retire  in  1  one instruction retired this cycle
  rdata  out  32  registered load data
  tx_data  out  8  byte to UART
  tx_valid  out  1  tx_data valid
  tx_ready  in  1  UART accepts byte
  rx_data  in  8  byte from UART
  rx_valid  in  1  rx_data valid
  rx_ready  out  1  block accepts RX byte

Function
REQ-004 The block SHALL decode offset addr[7:0] inside the window: 0x00 status (R), 0x04 RX data (R, pop), 0x08 TX data (W), 0x10 cycle count (R), 0x14 retired-instruction count (R), 0x18 counter reset (W).
REQ-005 Status SHALL read {30'b0, rx_full, tx_space}; tx_space = TX holding register empty (no FIFO) or FIFO not full (FIFO).
REQ-006 Loads SHALL have 1-cycle latency: rdata at cycle N+1 reflects state sampled at edge ending cycle N with re=1; rdata SHALL be 0 for unmapped offsets, addresses outside the window, or re=0.
REQ-007 rx_ready SHALL equal !rx_full combinationally; on rx_valid&&rx_ready the byte SHALL be latched and rx_full set at that edge.
REQ-008 A load from 0x04 SHALL return {24'b0, rx_byte} and clear rx_full at the same edge; a load from 0x04 with rx_full=0 SHALL return the stale byte and have no side effect.
REQ-009 Without FIFO: a store to 0x08 with tx_valid=0 SHALL load wdata[7:0] and set tx_valid next cycle; tx_valid SHALL stay high, tx_data stable, until an edge with tx_ready=1; a store while tx_valid=1 SHALL be dropped.
REQ-010 cycle_cnt SHALL increment every cycle; inst_cnt SHALL increment on inst_retire; both 32 bits, wrap 0xFFFF_FFFF->0.
REQ-011 A store to 0x18 (any data) SHALL set both counters to 0 at that edge, overriding that cycle's increment.
REQ-012 Simultaneous re and we SHALL perform both; the load returns the pre-edge value.
REQ-013 Stores to read-only offsets and loads from write-only offsets SHALL have no side effect.

Reset
REQ-014 On rst at a clock edge: rdata=0, tx_valid=0, tx_data=0, rx_full=0 (rx_ready=1), cycle_cnt=0, inst_cnt=0, FIFO pointers/count=0; rst SHALL override all same-cycle stores, loads and handshakes, discarding in-flight TX/RX bytes.

Configuration
REQ-015 With MMIO_TX_FIFO_EN defined, TX SHALL use a FIFO_DEPTH-entry FIFO: store to 0x08 pushes if not full (dropped if full at cycle start, even with a same-cycle pop); tx_valid = !empty; pop on tx_valid&&tx_ready; push into empty FIFO shows tx_valid the next cycle (no bypass); order preserved across pointer wrap.
REQ-016 Without MMIO_TX_FIFO_EN, TX SHALL use the single holding register of REQ-009 and FIFO_DEPTH is unused.

Verification
REQ-017 rst, 5 idle cycles, load 0x8000_0010 -> rdata=5 next cycle; load 0x8000_0000 -> rdata=0x1.
REQ-018 rx_valid=1, rx_data=0x5A for one cycle -> rx_ready=0 next cycle, status=0x3; load 0x04 -> rdata=0x5A, then status=0x1, rx_ready=1.
REQ-019 No FIFO: store 0x41 then 0x42 to 0x08 with tx_ready=0 -> tx_valid=1, tx_data=0x41; raise tx_ready one cycle -> tx_valid=0, 0x42 never sent.
REQ-020 FIFO (depth 4): push 0x10..0x14 with tx_ready=0 -> status bit0=0 after 4th, 0x14 dropped; tx_ready=1 -> bytes 0x10,0x11,0x12,0x13 in order, then tx_valid=0.
REQ-021 Preload cycle_cnt to 0xFFFF_FFFE via elapsed cycles/force -> wraps to 0; pulse inst_retire 3 cycles, store 0x18 in the 3rd -> both counters read 0 next cycle.
REQ-022 Assert rst while tx_valid=1 and rx_full=1 -> next cycle tx_valid=0, rx_ready=1, rdata=0, counters 0.
